// File: rtl/uart_tx_arb_pkg.sv
// rtl/uart_tx_arb_pkg.sv - shared state encodings for the UART TX arbiter
package uart_tx_arb_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arb_if.sv
// rtl/uart_tx_arb_if.sv - requester and UART TX controller handshake bundle
interface uart_tx_arb_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   ack;
    logic               tx_send;
    logic [7:0]         tx_data;
    logic               tx_ready;

    modport master (
        output req, req_data, tx_ready,
        input  ack, tx_send, tx_data
    );

    modport slave (
        input  req, req_data, tx_ready,
        output ack, tx_send, tx_data
    );
endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// rtl/uart_tx_arb_rr_pick.sv - rotate-priority encoder searching upward from last+1
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Walk candidates from farthest to nearest so the nearest set bit after last wins;
    // last itself is the final (lowest-priority) candidate.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req[(int'(last) + k) % N_REQ]) begin
                valid = 1'b1;
                idx   = IDX_W'((int'(last) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin arbiter sharing one UART TX controller
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int IDX_W   = 2,
    parameter int BUSY_TO = 8
) (
    input  logic             CLK,
    input  logic             RSTN,
    uart_tx_arb_if.slave     bus,
    output logic             busy,
    output logic [IDX_W-1:0] gnt_id,
    output logic             err
);

    localparam int CNT_W = $clog2(BUSY_TO + 1);

    arb_state_t         state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               tx_send_q, tx_send_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic               err_q, err_d;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (bus.req),
        .last  (gnt_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // State and registered outputs; reset abandons any in-flight byte without an ack.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= IDLE;
            cnt       <= '0;
            tx_send_q <= 1'b0;
            tx_data_q <= '0;
            ack_q     <= '0;
            gnt_q     <= IDX_W'(N_REQ - 1);
            err_q     <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            tx_send_q <= tx_send_d;
            tx_data_q <= tx_data_d;
            ack_q     <= ack_d;
            gnt_q     <= gnt_d;
            err_q     <= err_d;
        end
    end

    // Next state: grant only from IDLE with the transmitter idle, then follow ready
    // through a full low/high cycle before the next grant.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        tx_send_d = 1'b0;
        tx_data_d = tx_data_q;
        ack_d     = '0;
        gnt_d     = gnt_q;
        err_d     = err_q;
        case (state)
            IDLE: begin
                if (bus.tx_ready && pick_valid) begin
                    tx_data_d       = bus.req_data[8*int'(pick_idx) +: 8];
                    tx_send_d       = 1'b1;
                    ack_d[pick_idx] = 1'b1;
                    gnt_d           = pick_idx;
                    state_d         = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!bus.tx_ready) begin
                    state_d = WAIT_DONE;
                end else if (cnt == CNT_W'(BUSY_TO - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (bus.tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.tx_send = tx_send_q;
    assign bus.tx_data = tx_data_q;
    assign bus.ack     = ack_q;
    assign gnt_id      = gnt_q;
    assign err         = err_q;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - directed self-checking bench for uart_tx_arb
module tb_uart_tx_arb;

    logic       CLK;
    logic       RSTN;
    logic       busy;
    logic [1:0] gnt_id;
    logic       err;

    int checks   = 0;
    int failures = 0;

    uart_tx_arb_if #(.N_REQ(4)) bus ();

    uart_tx_arb #(
        .N_REQ   (4),
        .IDX_W   (2),
        .BUSY_TO (8)
    ) dut (
        .CLK    (CLK),
        .RSTN   (RSTN),
        .bus    (bus),
        .busy   (busy),
        .gnt_id (gnt_id),
        .err    (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // UART TX controller model: on a send, ready drops for m_len cycles
    logic m_busy = 1'b0;
    int   m_cnt  = 0;
    int   m_len  = 2;
    bit   m_hang = 1'b0;
    bit   m_hold_low = 1'b0;

    always @(posedge CLK) begin
        if (bus.tx_send && !m_hang) begin
            m_busy <= 1'b1;
            m_cnt  <= m_len;
        end else if (m_busy) begin
            if (m_cnt <= 1) m_busy <= 1'b0;
            else            m_cnt  <= m_cnt - 1;
        end
    end

    assign bus.tx_ready = !m_busy && !m_hold_low;

    // Monitor: log every send and protocol violations
    logic [7:0] sent_q[$];
    logic [3:0] ackv_q[$];
    int   low_send  = 0;
    int   ack_bad   = 0;
    int   dbl_send  = 0;
    bit   need_rise = 1'b0;
    logic prev_ready = 1'b1;

    always @(posedge CLK) begin
        if (!prev_ready && bus.tx_ready) need_rise = 1'b0;
        if (bus.tx_send === 1'b1) begin
            sent_q.push_back(bus.tx_data);
            ackv_q.push_back(bus.ack);
            if (!bus.tx_ready) low_send++;
            if (need_rise) dbl_send++;
            need_rise = 1'b1;
        end else if (bus.ack !== 4'b0000 && RSTN === 1'b1) begin
            ack_bad++;
        end
        prev_ready = bus.tx_ready;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 60) begin
            tick();
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_send(input string tag);
        int n = 0;
        while (bus.tx_send !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.tx_send), 32'd1);
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        tick();
        tick();
        RSTN = 1'b1;
    endtask

    initial begin
        int base;
        int dbl_base;
        int n;
        bit seen;

        RSTN         = 1'b0;
        bus.req      = '0;
        bus.req_data = '0;
        tick();
        tick();
        chk("rst_tx_send", 32'(bus.tx_send), 32'd0);
        chk("rst_ack",     32'(bus.ack),     32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_gnt_id",  32'(gnt_id),      32'd3);
        chk("rst_err",     32'(err),         32'd0);
        chk("rst_busy",    32'(busy),        32'd0);
        RSTN = 1'b1;

        // 1: single byte, one-cycle latency
        tick();
        bus.req = 4'b0001;
        bus.req_data[7:0] = 8'hA5;
        tick();
        chk("t1_tx_send", 32'(bus.tx_send), 32'd1);
        chk("t1_ack",     32'(bus.ack),     32'h1);
        chk("t1_tx_data", 32'(bus.tx_data), 32'hA5);
        chk("t1_gnt_id",  32'(gnt_id),      32'd0);
        bus.req = 4'b0000;
        tick();
        chk("t1_send_low", 32'(bus.tx_send),  32'd0);
        chk("t1_ack_low",  32'(bus.ack),      32'd0);
        chk("t1_ready_dn", 32'(bus.tx_ready), 32'd0);
        chk("t1_busy_hi",  32'(busy),         32'd1);
        wait_idle("t1_idle");

        // 2: all requesting, 10-cycle frames, fair rotation from reset
        do_reset();
        m_len = 10;
        for (int i = 0; i < 4; i++) bus.req_data[8*i +: 8] = 8'h10 + 8'(i);
        base     = sent_q.size();
        dbl_base = dbl_send;
        bus.req  = 4'b1111;
        n = 0;
        while (sent_q.size() - base < 5 && n < 400) begin
            tick();
            n++;
        end
        bus.req = 4'b0000;
        chk("t2_count", 32'(sent_q.size() - base), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (base + k < sent_q.size()) begin
                chk($sformatf("t2_data%0d", k), 32'(sent_q[base+k]), 32'h10 + 32'(k % 4));
                chk($sformatf("t2_ack%0d", k),  32'(ackv_q[base+k]), 32'd1 << (k % 4));
            end
        end
        wait_idle("t2_idle");
        chk("t2_dbl_send", 32'(dbl_send - dbl_base), 32'd0);

        // 3: transmitter not ready blocks grant
        m_len = 2;
        m_hold_low = 1'b1;
        bus.req = 4'b0010;
        bus.req_data[15:8] = 8'h3C;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.tx_send !== 1'b0 || bus.ack !== 4'b0000 || busy !== 1'b0) seen = 1'b1;
        end
        chk("t3_blocked", 32'(seen), 32'd0);
        m_hold_low = 1'b0;
        tick();
        chk("t3_tx_send", 32'(bus.tx_send), 32'd1);
        chk("t3_ack",     32'(bus.ack),     32'h2);
        chk("t3_tx_data", 32'(bus.tx_data), 32'h3C);
        chk("t3_gnt_id",  32'(gnt_id),      32'd1);
        bus.req = 4'b0000;
        wait_idle("t3_idle");

        // 4: transmitter never responds -> timeout sets sticky err
        m_hang = 1'b1;
        bus.req = 4'b0100;
        bus.req_data[23:16] = 8'h77;
        tick();
        chk("t4_tx_send", 32'(bus.tx_send), 32'd1);
        bus.req = 4'b0000;
        tick();
        repeat (7) tick();
        chk("t4_err_early", 32'(err),  32'd0);
        chk("t4_busy_late", 32'(busy), 32'd1);
        tick();
        chk("t4_err_set",  32'(err),  32'd1);
        chk("t4_busy_dn",  32'(busy), 32'd0);
        m_hang = 1'b0;
        bus.req = 4'b1000;
        bus.req_data[31:24] = 8'h99;
        tick();
        chk("t4_next_data", 32'(bus.tx_data), 32'h99);
        chk("t4_next_gnt",  32'(gnt_id),      32'd3);
        bus.req = 4'b0000;
        wait_idle("t4_idle");
        chk("t4_err_sticky", 32'(err), 32'd1);

        // 5: asynchronous reset during WAIT_DONE
        m_len = 10;
        bus.req = 4'b0001;
        bus.req_data[7:0] = 8'h5A;
        tick();
        bus.req = 4'b0000;
        tick();
        tick();
        chk("t5_in_frame", 32'(busy), 32'd1);
        #2;
        RSTN = 1'b0;
        #1;
        chk("t5_busy",    32'(busy),        32'd0);
        chk("t5_gnt_id",  32'(gnt_id),      32'd3);
        chk("t5_err",     32'(err),         32'd0);
        chk("t5_tx_send", 32'(bus.tx_send), 32'd0);
        chk("t5_ack",     32'(bus.ack),     32'd0);
        chk("t5_tx_data", 32'(bus.tx_data), 32'd0);
        tick();
        tick();
        RSTN = 1'b1;
        bus.req = 4'b0100;
        bus.req_data[23:16] = 8'hC3;
        wait_send("t5_send");
        chk("t5_g_ack",  32'(bus.ack),     32'h4);
        chk("t5_g_gnt",  32'(gnt_id),      32'd2);
        chk("t5_g_data", 32'(bus.tx_data), 32'hC3);
        bus.req = 4'b0000;
        wait_idle("t5_idle");

        // 6: req change during WAIT_DONE, search resumes after gnt_id=1
        bus.req = 4'b0010;
        bus.req_data[15:8] = 8'h11;
        tick();
        chk("t6_gnt1", 32'(gnt_id), 32'd1);
        bus.req = 4'b0001;
        tick();
        tick();
        bus.req = 4'b1001;
        bus.req_data[7:0]   = 8'hD0;
        bus.req_data[31:24] = 8'hD3;
        tick();
        wait_send("t6_send_a");
        chk("t6_a_gnt",  32'(gnt_id),      32'd3);
        chk("t6_a_data", 32'(bus.tx_data), 32'hD3);
        chk("t6_a_ack",  32'(bus.ack),     32'h8);
        bus.req = 4'b0001;
        tick();
        wait_send("t6_send_b");
        chk("t6_b_gnt",  32'(gnt_id),      32'd0);
        chk("t6_b_data", 32'(bus.tx_data), 32'hD0);
        chk("t6_b_ack",  32'(bus.ack),     32'h1);
        bus.req = 4'b0000;
        wait_idle("t6_idle");

        chk("send_while_not_ready", 32'(low_send), 32'd0);
        chk("ack_without_send",     32'(ack_bad),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
